// File: rtl/dzcpu_useq_if.sv
// dzcpu_useq_if: bus between the micro-sequencer and fetch/LUT/ROM/datapath.
// The master modport is the sequencer side (drives o*, samples i*).
// The slave modport is the environment side (memory, LUTs, ROM, flags).
interface dzcpu_useq_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic [7:0]        iMop;
    logic              iMopValid;
    logic              iStall;
    logic [ADDR_W-1:0] iLutIdx;
    logic [ADDR_W-1:0] iCbLutIdx;
    logic [3:0]        iFlow;
    logic              iJcb;
    logic              iZ;
    logic [7:0]        oMop;
    logic [ADDR_W-1:0] oUopAddr;
    logic              oUopValid;
    logic              oFetchReq;
    logic              oIncPc;
    logic              oFlagsUpdate;
    logic              oEof;
    logic [CNT_W-1:0]  oInstrCount;
    logic              oFlowError;

    modport master (
        input  iMop, iMopValid, iStall, iLutIdx, iCbLutIdx, iFlow, iJcb, iZ,
        output oMop, oUopAddr, oUopValid, oFetchReq, oIncPc, oFlagsUpdate,
               oEof, oInstrCount, oFlowError
    );

    modport slave (
        output iMop, iMopValid, iStall, iLutIdx, iCbLutIdx, iFlow, iJcb, iZ,
        input  oMop, oUopAddr, oUopValid, oFetchReq, oIncPc, oFlagsUpdate,
               oEof, oInstrCount, oFlowError
    );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: micro-sequencer latching macro-opcodes and stepping the micro-op ROM.
// Ports: iClock/iReset (sync, active-high) plus bus (dzcpu_useq_if.master):
//   inputs  iMop/iMopValid fetch byte, iStall wait, iLutIdx/iCbLutIdx flow
//           indices, iFlow/iJcb current micro-op fields, iZ flag
//   outputs oMop latched opcode, oUopAddr micro-PC, oUopValid, oFetchReq,
//           oIncPc, oFlagsUpdate, oEof, oInstrCount, sticky oFlowError
module dzcpu_useq #(
    parameter int ADDR_W       = 8,
    parameter int MAX_FLOW_LEN = 32,
    parameter int CNT_W        = 16
) (
    input logic            iClock,
    input logic            iReset,
    dzcpu_useq_if.master   bus
);
    // One spare bit so the flow length can sit at the limit after a CB jump.
    localparam int LEN_W = $clog2(MAX_FLOW_LEN) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, CBDECODE} state_t;

    state_t           state;
    logic [LEN_W-1:0] flow_len;
    logic             inc_code, fu_code, eof_code, run, limit, retire;

    always_comb begin
        inc_code = bus.iFlow inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7};
        fu_code  = bus.iFlow inside {4'd4, 4'd5, 4'd8};
        eof_code = (bus.iFlow inside {[4'd2:4'd5]}) ||
                   (bus.iFlow == 4'd6 && bus.iZ) ||
                   (bus.iFlow == 4'd7 && !bus.iZ);
        // A CB jump without its operand byte behaves like a stall.
        run      = !iReset && state == EXEC && !bus.iStall && (!bus.iJcb || bus.iMopValid);
        limit    = flow_len >= LEN_W'(MAX_FLOW_LEN - 1);
        retire   = run && !bus.iJcb && (eof_code || limit);
    end

    assign bus.oUopValid    = run;
    assign bus.oIncPc       = run && inc_code;
    assign bus.oFlagsUpdate = run && !bus.iJcb && fu_code;
    assign bus.oEof         = retire;
    assign bus.oFetchReq    = !iReset && state == FETCH;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state           <= IDLE;
            bus.oMop        <= '0;
            bus.oUopAddr    <= '0;
            flow_len        <= '0;
            bus.oInstrCount <= '0;
            bus.oFlowError  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: if (bus.iMopValid) begin
                    bus.oMop <= bus.iMop;
                    flow_len <= '0;
                    state    <= DECODE;
                end
                DECODE: begin
                    bus.oUopAddr <= bus.iLutIdx;
                    state        <= EXEC;
                end
                CBDECODE: begin
                    bus.oUopAddr <= bus.iCbLutIdx;
                    state        <= EXEC;
                end
                EXEC: if (run) begin
                    if (bus.iJcb) begin
                        bus.oMop <= bus.iMop;
                        flow_len <= flow_len + LEN_W'(!limit);
                        state    <= CBDECODE;
                    end else if (retire) begin
                        bus.oInstrCount <= bus.oInstrCount + CNT_W'(1);
                        // Retiring without an end-of-flow code means the watchdog fired.
                        if (!eof_code) bus.oFlowError <= 1'b1;
                        state <= FETCH;
                    end else begin
                        bus.oUopAddr <= bus.oUopAddr + ADDR_W'(1);
                        flow_len     <= flow_len + LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: directed bench with an end-of-flow scoreboard for dzcpu_useq.
module tb_dzcpu_useq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_valid = 1'b0;
    logic [3:0] rom [256];
    logic       jcb [256];
    int         errors = 0;
    int         checks = 0;
    int         sb [$];
    int         retired = 0;

    dzcpu_useq_if #(.ADDR_W(8), .CNT_W(16)) u_if ();
    dzcpu_useq_if #(.ADDR_W(8), .CNT_W(4))  w_if ();

    dzcpu_useq #(.ADDR_W(8), .MAX_FLOW_LEN(32), .CNT_W(16)) dut (
        .iClock(clk), .iReset(rst), .bus(u_if.master)
    );

    dzcpu_useq #(.ADDR_W(8), .MAX_FLOW_LEN(4), .CNT_W(4)) wd (
        .iClock(clk), .iReset(rst), .bus(w_if.master)
    );

    always #5 clk = ~clk;

    assign u_if.iFlow     = rom[u_if.oUopAddr];
    assign u_if.iJcb      = jcb[u_if.oUopAddr];
    assign w_if.iMop      = u_if.iMop;
    assign w_if.iMopValid = w_valid;
    assign w_if.iStall    = 1'b0;
    assign w_if.iLutIdx   = 8'd40;
    assign w_if.iCbLutIdx = 8'd0;
    assign w_if.iFlow     = 4'd0;
    assign w_if.iJcb      = 1'b0;
    assign w_if.iZ        = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every retirement must match the oldest pending instruction.
    always @(negedge clk) begin
        if (rst) retired = 0;
        else if (u_if.oEof) begin
            chk("eof_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                chk("eof_addr", u_if.oUopAddr, sb.pop_front());
                chk("eof_count", u_if.oInstrCount, retired & 32'hFFFF);
                retired++;
            end
        end
    end

    task automatic fetch(input logic [7:0] mop, input logic [7:0] idx, input int end_addr);
        u_if.iMop = mop;
        u_if.iMopValid = 1'b1;
        u_if.iLutIdx = idx;
        if (end_addr >= 0) sb.push_back(end_addr);
        #1 chk("fetch_req", u_if.oFetchReq, 1);
        step;
        u_if.iMopValid = 1'b0;
        #1 chk("latched_mop", u_if.oMop, mop);
        chk("decode_no_uop", u_if.oUopValid, 0);
        step;
    endtask

    task automatic uop(input logic [7:0] addr, input logic inc, input logic fu, input logic eof);
        #1 chk($sformatf("uop_addr@%0d", addr), u_if.oUopAddr, addr);
        chk($sformatf("uop_valid@%0d", addr), u_if.oUopValid, 1);
        chk($sformatf("inc_pc@%0d", addr), u_if.oIncPc, inc);
        chk($sformatf("flags_update@%0d", addr), u_if.oFlagsUpdate, fu);
        chk($sformatf("eof@%0d", addr), u_if.oEof, eof);
        step;
    endtask

    task automatic wd_instr;
        w_valid = 1'b1;
        #1 chk("wd_fetch_req", w_if.oFetchReq, 1);
        step;
        w_valid = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            #1 chk("wd_addr", w_if.oUopAddr, 40 + i);
            chk("wd_eof", w_if.oEof, 32'(i == 3));
            step;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 4'd0;
            jcb[i] = 1'b0;
        end
        rom[1] = 4'd1; rom[2] = 4'd1; rom[3] = 4'd0; rom[4] = 4'd3;
        rom[5] = 4'd1; rom[6] = 4'd2;
        rom[14] = 4'd12; rom[15] = 4'd3; jcb[15] = 1'b1; rom[16] = 4'd4;
        rom[19] = 4'd6; rom[22] = 4'd2;
        rom[255] = 4'd8; rom[0] = 4'd3;
        u_if.iMop = 8'h00; u_if.iMopValid = 1'b0; u_if.iStall = 1'b0;
        u_if.iLutIdx = 8'd0; u_if.iCbLutIdx = 8'd0; u_if.iZ = 1'b0;
        repeat (3) step;
        chk("rst_mop", u_if.oMop, 0);
        chk("rst_addr", u_if.oUopAddr, 0);
        chk("rst_count", u_if.oInstrCount, 0);
        chk("rst_error", u_if.oFlowError, 0);
        chk("rst_fetch_req", u_if.oFetchReq, 0);
        rst = 1'b0;
        #1 chk("idle_fetch_req", u_if.oFetchReq, 0);
        step;
        // Basic flow {INC,INC,OP,INC_EOF}.
        fetch(8'h31, 8'd1, 4);
        uop(1, 1, 0, 0); uop(2, 1, 0, 0); uop(3, 0, 0, 0); uop(4, 1, 0, 1);
        #1 chk("post_eof_fetch_req", u_if.oFetchReq, 1);
        chk("post_eof_addr", u_if.oUopAddr, 4);
        chk("count_1", u_if.oInstrCount, 1);
        // CB prefix, first without the operand byte.
        fetch(8'hCB, 8'd13, 16);
        uop(13, 0, 0, 0); uop(14, 0, 0, 0);
        #1 chk("jcb_wait_valid", u_if.oUopValid, 0);
        chk("jcb_wait_inc", u_if.oIncPc, 0);
        chk("jcb_wait_addr", u_if.oUopAddr, 15);
        step;
        u_if.iMop = 8'h7C; u_if.iMopValid = 1'b1; u_if.iCbLutIdx = 8'd16;
        uop(15, 1, 0, 0);
        u_if.iMopValid = 1'b0;
        #1 chk("cb_mop", u_if.oMop, 8'h7C);
        chk("cbdecode_valid", u_if.oUopValid, 0);
        step;
        uop(16, 0, 1, 1);
        // Z-conditional end, taken then not taken.
        u_if.iZ = 1'b1;
        fetch(8'h28, 8'd17, 19);
        uop(17, 0, 0, 0); uop(18, 0, 0, 0); uop(19, 1, 0, 1);
        u_if.iZ = 1'b0;
        fetch(8'h20, 8'd17, 22);
        uop(17, 0, 0, 0); uop(18, 0, 0, 0); uop(19, 1, 0, 0);
        uop(20, 0, 0, 0); uop(21, 0, 0, 0); uop(22, 0, 0, 1);
        // Stalls on a normal micro-op and on an end-of-flow micro-op.
        fetch(8'h05, 8'd5, 6);
        u_if.iStall = 1'b1;
        repeat (3) begin
            #1 chk("stall_addr", u_if.oUopAddr, 5);
            chk("stall_valid", u_if.oUopValid, 0);
            chk("stall_inc", u_if.oIncPc, 0);
            step;
        end
        u_if.iStall = 1'b0;
        uop(5, 1, 0, 0);
        u_if.iStall = 1'b1;
        repeat (2) begin
            #1 chk("stall_eof", u_if.oEof, 0);
            chk("stall_eof_addr", u_if.oUopAddr, 6);
            step;
        end
        u_if.iStall = 1'b0;
        uop(6, 0, 0, 1);
        // Micro-PC wraps from 255 to 0; code 8 updates flags only.
        fetch(8'h00, 8'd255, 0);
        uop(255, 0, 1, 0); uop(0, 1, 0, 1);
        #1 chk("count_6", u_if.oInstrCount, 6);
        chk("main_no_error", u_if.oFlowError, 0);
        // Watchdog on the MAX_FLOW_LEN=4 instance.
        wd_instr;
        #1 chk("wd_error_set", w_if.oFlowError, 1);
        wd_instr;
        #1 chk("wd_error_sticky", w_if.oFlowError, 1);
        chk("wd_count_2", w_if.oInstrCount, 2);
        // Reset in the middle of a flow.
        fetch(8'h3E, 8'd50, -1);
        uop(50, 0, 0, 0); uop(51, 0, 0, 0);
        #1 chk("pre_rst_addr", u_if.oUopAddr, 52);
        rst = 1'b1;
        #1 chk("rst_comb_valid", u_if.oUopValid, 0);
        chk("rst_comb_eof", u_if.oEof, 0);
        step;
        rst = 1'b0;
        #1 chk("mid_rst_addr", u_if.oUopAddr, 0);
        chk("mid_rst_count", u_if.oInstrCount, 0);
        chk("mid_rst_mop", u_if.oMop, 0);
        chk("mid_rst_idle", u_if.oFetchReq, 0);
        chk("wd_error_cleared", w_if.oFlowError, 0);
        chk("wd_count_cleared", w_if.oInstrCount, 0);
        step;
        // Retirement counter wraps (4-bit counter on the watchdog instance).
        repeat (15) wd_instr;
        #1 chk("wd_count_15", w_if.oInstrCount, 15);
        wd_instr;
        #1 chk("wd_count_wrap", w_if.oInstrCount, 0);
        fetch(8'h31, 8'd1, 4);
        uop(1, 1, 0, 0); uop(2, 1, 0, 0); uop(3, 0, 0, 0); uop(4, 1, 0, 1);
        #1 chk("count_after_rst", u_if.oInstrCount, 1);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Micro-sequencer for the dzcpu core: latches the fetched macro-opcode and presents it to the opcode/CB lookup tables.
- Loads the returned flow index into a micro-PC and steps the micro-op ROM one entry per cycle until the flow signals end-of-flow.
- Handles the 0xCB prefix re-dispatch, Z-conditional early termination, memory stalls and a runaway-flow watchdog.
- Sits between the fetch/memory interface, the ucode LUT/ROM and the execute datapath.

Parameters:
ADDR_W, 8, width of micro-PC / ROM address and LUT indices
MAX_FLOW_LEN, 32, micro-ops allowed per flow before forced termination (2..2^ADDR_W)
CNT_W, 16, width of retired-instruction counter

Ports:
iClock  in  1  clock; all state changes on rising edge
iReset  in  1  synchronous, active-high reset
iMop  in  8  opcode byte from memory data bus
iMopValid  in  1  iMop valid this cycle
iStall  in  1  memory/datapath wait; freezes sequencing
iLutIdx  in  ADDR_W  flow index from opcode LUT for oMop (combinational)
iCbLutIdx  in  ADDR_W  flow index from CB LUT for oMop (combinational)
iFlow  in  4  flow-control field of micro-op at oUopAddr
iJcb  in  1  micro-op at oUopAddr is the CB jump
iZ  in  1  current Z flag
oMop  out  8  latched opcode, drives both LUTs
oUopAddr  out  ADDR_W  micro-PC, drives ROM address
oUopValid  out  1  execute the micro-op at oUopAddr this cycle
oFetchReq  out  1  sequencer waiting for an opcode byte
oIncPc  out  1  increment PC this cycle
oFlagsUpdate  out  1  commit ALU flags this cycle
oEof  out  1  one-cycle pulse, instruction retired
oInstrCount  out  CNT_W  retired-instruction count
oFlowError  out  1  sticky watchdog error

Behaviour:
- Flow codes (iFlow): 0 OP, 1 INC, 2 EOF, 3 INC_EOF, 4 EOF_FU, 5 INC_EOF_FU, 6 INC_EOF_Z, 7 INC_EOF_NZ, 8 UPDATE_FLAGS, 9-15 treated as OP.
- INC-class codes (1,3,5,6,7) assert oIncPc. FU codes (4,5,8) assert oFlagsUpdate.
- End-of-flow: codes 2-5; code 6 when iZ=1; code 7 when iZ=0. Otherwise micro-PC advances by 1, wrapping mod 2^ADDR_W.
- States: IDLE, FETCH, DECODE, EXEC, CBDECODE. Registered; all other outputs are combinational from state/inputs except counters and oFlowError.
- Reset: state=IDLE, oMop=0, oUopAddr=0, flow length counter=0, oInstrCount=0, oFlowError=0. All combinational outputs read 0 during reset.
- IDLE: outputs 0; next cycle -> FETCH.
- FETCH: oFetchReq=1. On iMopValid: oMop<=iMop, flow length counter<=0, -> DECODE. Otherwise hold.
- DECODE: oUopAddr<=iLutIdx, -> EXEC. Index 0 is the legal default 1-byte flow. Fetch-to-first-uop latency is 2 cycles.
- EXEC, oUopValid=~iStall. While iStall=1: nothing advances, oIncPc/oFlagsUpdate/oEof=0.
- EXEC, iJcb=1: flow code is ignored except its INC bit, which still drives oIncPc. Requires iMopValid in the same cycle; if iMopValid=0, treated as a stall and oUopValid=0. When iMopValid=1: oMop<=iMop, -> CBDECODE.
- CBDECODE: oUopAddr<=iCbLutIdx, -> EXEC. The flow length counter is not reset.
- EXEC, end-of-flow: oEof=1, oInstrCount<=oInstrCount+1 (wraps), -> FETCH. oUopAddr is unchanged until the next DECODE.
- Watchdog: the flow length counter increments on each executed micro-op without end-of-flow. When an executed micro-op would be number MAX_FLOW_LEN without end-of-flow, it is forced to end-of-flow: oEof=1, count increments, oFlowError<=1 (cleared only by reset), -> FETCH.
- Precedence: iReset > iStall > iJcb > end-of-flow/watchdog > advance.
- Reset mid-flow: flow abandoned, no oEof, counter cleared.

Test Plan:
- Reset, then iMop=0x31 valid with iLutIdx=1, ROM flows {INC,INC,OP,INC_EOF} -> oUopAddr 1,2,3,4 on consecutive cycles. oIncPc high at addresses 1, 2 and 4. oEof at addr 4, oInstrCount=1, oFetchReq on the next cycle.
- CB prefix: iLutIdx=13, micro-op 15 has iJcb=1 with iMop=0x7C and iCbLutIdx=16, addr 16 flow EOF_FU -> oMop=0x7C, oUopAddr 13,14,15,16. oFlagsUpdate and oEof at 16.
- Conditional: flow index 17, addr 19 code INC_EOF_Z. With iZ=1: oEof at 19, oIncPc=1. With iZ=0: continues to 20,21,22, EOF at 22.
- Stall: iStall=1 for 3 cycles at addr 5 -> oUopAddr held at 5, oUopValid/oIncPc=0; resumes at 6 after release. iStall together with EOF code -> no oEof until iStall=0.
- Watchdog: MAX_FLOW_LEN=4, all-OP ROM -> forced oEof on the 4th executed micro-op, oFlowError=1 and stays 1 across later instructions until iReset.
- Reset mid-flow at addr 52 -> next cycle state IDLE, oUopAddr=0, oInstrCount=0, no oEof. Also: 65535 retirements then one more -> oInstrCount wraps to 0.
